// File: rtl/ddr2_rb_pkg.sv
// Shared types and constants for the parametrised DDR2 read-capture ring buffer.
package ddr2_rb_pkg;

  typedef enum logic [1:0] {
    RB_IDLE    = 2'd0,
    RB_ARMED   = 2'd1,
    RB_CAPTURE = 2'd2
  } rb_state_e;

  localparam int unsigned STRAY_CNT_W = 8;

endpackage

// File: rtl/ddr2_rb_edge_det.sv
// Strobe register and toggle detect: every change of strobe level is one capture edge.
module ddr2_rb_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe,
  output logic strobe_edge
);

  logic strobe_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= strobe;
    end
  end

  assign strobe_edge = strobe ^ strobe_q;

endmodule

// File: rtl/ddr2_ring_buffer_param.sv
// Parametrised DDR2 read-capture ring buffer with burst length, arm timeout and indexed read-out.
// Optional stray-edge flag/counter ports are built when DDR2_RB_STRAY_EN is defined.
module ddr2_ring_buffer_param
  import ddr2_rb_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     listen,
  input  logic [$clog2(DEPTH):0]   burst_words,
  input  logic                     strobe,
  input  logic [DATA_W-1:0]        din,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic                     busy,
  output logic                     done,
`ifdef DDR2_RB_STRAY_EN
  output logic                     stray,
  output logic [STRAY_CNT_W-1:0]   stray_cnt,
`endif
  output logic                     timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TimerLast = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam bit TimeoutEn = (TIMEOUT != 0);

  rb_state_e         state_q, state_d;
  logic [CW-1:0]     remaining_q, remaining_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              mem_we;
  logic              strobe_edge;
  logic [CW-1:0]     burst_load;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q;

  ddr2_rb_edge_det u_edge_det (
    .clk        (clk),
    .reset_n    (reset_n),
    .strobe     (strobe),
    .strobe_edge(strobe_edge)
  );

  // Zero or oversize requests capture a full ring.
  assign burst_load = ((burst_words == '0) || (burst_words > CW'(DEPTH))) ? CW'(DEPTH)
                                                                          : burst_words;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    wr_ptr_d    = wr_ptr_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    mem_we      = 1'b0;

    unique case (state_q)
      RB_IDLE: begin
        if (listen) begin
          state_d     = RB_ARMED;
          remaining_d = burst_load;
          timer_d     = '0;
        end
      end
      RB_ARMED: begin
        if (strobe_edge) begin
          mem_we      = 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CW'(1)) begin
            state_d = RB_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RB_CAPTURE;
          end
        end else if (TimeoutEn && (timer_q == TimerLast)) begin
          state_d   = RB_IDLE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RB_CAPTURE: begin
        if (strobe_edge) begin
          mem_we      = 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CW'(1)) begin
            state_d = RB_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = RB_IDLE;
      end
    endcase

    if (mem_we) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RB_IDLE;
      remaining_q <= '0;
      timer_q     <= '0;
      wr_ptr_q    <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      wr_ptr_q    <= wr_ptr_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  // Read register has no bypass: a write becomes visible one cycle after it lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      dout_q <= '0;
    end else begin
      if (mem_we) begin
        mem_q[wr_ptr_q] <= din;
      end
      dout_q <= mem_q[rd_ptr];
    end
  end

`ifdef DDR2_RB_STRAY_EN
  logic                   stray_q;
  logic [STRAY_CNT_W-1:0] stray_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stray_q     <= 1'b0;
      stray_cnt_q <= '0;
    end else if (strobe_edge && (state_q == RB_IDLE)) begin
      stray_q <= 1'b1;
      if (stray_cnt_q != '1) begin
        stray_cnt_q <= stray_cnt_q + 1'b1;
      end
    end
  end

  assign stray     = stray_q;
  assign stray_cnt = stray_cnt_q;
`endif

  assign dout    = dout_q;
  assign wr_ptr  = wr_ptr_q;
  assign busy    = (state_q != RB_IDLE);
  assign done    = done_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_ddr2_ring_buffer_param.sv
// Directed self-checking bench for ddr2_ring_buffer_param (DEPTH=8, TIMEOUT=64).
module tb_ddr2_ring_buffer_param;

  logic        clk;
  logic        reset_n;
  logic        listen;
  logic [3:0]  burst_words;
  logic        strobe;
  logic [15:0] din;
  logic [2:0]  rd_ptr;
  logic [15:0] dout;
  logic [2:0]  wr_ptr;
  logic        busy;
  logic        done;
  logic        timeout;
`ifdef DDR2_RB_STRAY_EN
  logic        stray;
  logic [7:0]  stray_cnt;
`endif

  int total;
  int bad;

  ddr2_ring_buffer_param #(
    .DATA_W (16),
    .DEPTH  (8),
    .TIMEOUT(64)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .listen     (listen),
    .burst_words(burst_words),
    .strobe     (strobe),
    .din        (din),
    .rd_ptr     (rd_ptr),
    .dout       (dout),
    .wr_ptr     (wr_ptr),
    .busy       (busy),
    .done       (done),
`ifdef DDR2_RB_STRAY_EN
    .stray      (stray),
    .stray_cnt  (stray_cnt),
`endif
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic toggle(input logic [15:0] data);
    din    = data;
    strobe = ~strobe;
    step();
  endtask

  task automatic arm(input logic [3:0] bw);
    burst_words = bw;
    listen      = 1'b1;
    step();
    listen      = 1'b0;
  endtask

  task automatic rd(input int idx);
    rd_ptr = 3'(idx);
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    total++;
    if ({dout, wr_ptr, busy, done, timeout} !== 22'd0) begin
      bad++;
      $display("FAIL reset_outputs: dout=%h wr_ptr=%0d busy=%b done=%b timeout=%b, want all 0",
               dout, wr_ptr, busy, done, timeout);
    end
`ifdef DDR2_RB_STRAY_EN
    total++;
    if ({stray, stray_cnt} !== 9'd0) begin
      bad++;
      $display("FAIL reset_stray: stray=%b cnt=%0d, want 0/0", stray, stray_cnt);
    end
`endif
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_full_burst();
    int done_seen;
    done_seen = 0;
    arm(4'd8);
    for (int i = 0; i < 8; i++) begin
      toggle(16'(16'h1111 * i));
      if (done) done_seen++;
      if (i < 7) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL full_busy[%0d]: busy=%b, want 1", i, busy);
        end
      end
    end
    total++;
    if (busy !== 1'b0 || wr_ptr !== 3'd0) begin
      bad++;
      $display("FAIL full_end: busy=%b wr_ptr=%0d, want 0/0", busy, wr_ptr);
    end
    step();
    if (done) done_seen++;
    total++;
    if (done_seen != 1) begin
      bad++;
      $display("FAIL full_done_count: got %0d pulses, want 1", done_seen);
    end
    for (int i = 0; i < 8; i++) begin
      rd(i);
      total++;
      if (dout !== 16'(16'h1111 * i)) begin
        bad++;
        $display("FAIL full_read[%0d]: dout=%h, want %h", i, dout, 16'(16'h1111 * i));
      end
    end
  endtask

  task automatic test_half_bursts();
    logic [15:0] vals [4];
    vals = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    arm(4'd4);
    for (int i = 0; i < 4; i++) toggle(vals[i]);
    total++;
    if (done !== 1'b1 || wr_ptr !== 3'd4) begin
      bad++;
      $display("FAIL half1_end: done=%b wr_ptr=%0d, want 1/4", done, wr_ptr);
    end
    step();
    for (int i = 0; i < 8; i++) begin
      rd(i);
      total++;
      if (dout !== ((i < 4) ? vals[i] : 16'(16'h1111 * i))) begin
        bad++;
        $display("FAIL half1_read[%0d]: dout=%h", i, dout);
      end
    end
    arm(4'd4);
    for (int i = 0; i < 4; i++) toggle(vals[i]);
    total++;
    if (done !== 1'b1 || wr_ptr !== 3'd0) begin
      bad++;
      $display("FAIL half2_end: done=%b wr_ptr=%0d, want 1/0", done, wr_ptr);
    end
    step();
    for (int i = 4; i < 8; i++) begin
      rd(i);
      total++;
      if (dout !== vals[i-4]) begin
        bad++;
        $display("FAIL half2_read[%0d]: dout=%h, want %h", i, dout, vals[i-4]);
      end
    end
  endtask

  task automatic test_stray();
    for (int i = 0; i < 8; i++) toggle(16'h5A5A);
    total++;
    if (wr_ptr !== 3'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stray_state: wr_ptr=%0d busy=%b, want 0/0", wr_ptr, busy);
    end
    rd(1);
    total++;
    if (dout !== 16'hBBBB) begin
      bad++;
      $display("FAIL stray_mem1: dout=%h, want bbbb", dout);
    end
    rd(6);
    total++;
    if (dout !== 16'hCCCC) begin
      bad++;
      $display("FAIL stray_mem6: dout=%h, want cccc", dout);
    end
`ifdef DDR2_RB_STRAY_EN
    total++;
    if (stray !== 1'b1 || stray_cnt !== 8'd8) begin
      bad++;
      $display("FAIL stray_flag: stray=%b cnt=%0d, want 1/8", stray, stray_cnt);
    end
`endif
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    rd_ptr = 3'd0;
    arm(4'd8);
    for (int k = 1; k <= 63; k++) begin
      step();
      if (timeout !== 1'b0 || busy !== 1'b1) early++;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL timeout_early: %0d bad cycles before expiry, want 0", early);
    end
    step();
    total++;
    if (timeout !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_pulse: timeout=%b busy=%b, want 1/0", timeout, busy);
    end
    step();
    total++;
    if (timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_width: timeout=%b, want 0", timeout);
    end
    toggle(16'hEEEE);
    step();
    total++;
    if (wr_ptr !== 3'd0 || dout !== 16'hAAAA) begin
      bad++;
      $display("FAIL timeout_late_edge: wr_ptr=%0d dout=%h, want 0/aaaa", wr_ptr, dout);
    end
  endtask

  task automatic test_reset_mid_burst();
    arm(4'd8);
    toggle(16'h0101);
    toggle(16'h0202);
    toggle(16'h0303);
    reset_n = 1'b0;
    strobe  = 1'b0;
    #2;
    total++;
    if (dout !== 16'h0 || wr_ptr !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: dout=%h wr_ptr=%0d busy=%b done=%b, want 0/0/0/0",
               dout, wr_ptr, busy, done);
    end
    reset_n = 1'b1;
    step();
    total++;
    if (done !== 1'b0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_pulse: done=%b timeout=%b, want 0/0", done, timeout);
    end
    arm(4'd2);
    toggle(16'h1234);
    toggle(16'h5678);
    total++;
    if (wr_ptr !== 3'd2 || done !== 1'b1) begin
      bad++;
      $display("FAIL fresh_end: wr_ptr=%0d done=%b, want 2/1", wr_ptr, done);
    end
    rd(0);
    total++;
    if (dout !== 16'h1234) begin
      bad++;
      $display("FAIL fresh_read0: dout=%h, want 1234", dout);
    end
    rd(1);
    total++;
    if (dout !== 16'h5678) begin
      bad++;
      $display("FAIL fresh_read1: dout=%h, want 5678", dout);
    end
    rd(2);
    total++;
    if (dout !== 16'h0000) begin
      bad++;
      $display("FAIL fresh_read2: dout=%h, want 0000", dout);
    end
  endtask

  task automatic test_read_latency();
    reset_n = 1'b0;
    strobe  = 1'b0;
    rd_ptr  = 3'd0;
    #2;
    reset_n = 1'b1;
    step();
    arm(4'd1);
    toggle(16'hBEEF);
    total++;
    if (dout !== 16'h0000 || done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL latency_n1: dout=%h done=%b busy=%b, want 0000/1/0", dout, done, busy);
    end
    step();
    total++;
    if (dout !== 16'hBEEF) begin
      bad++;
      $display("FAIL latency_n2: dout=%h, want beef", dout);
    end
  endtask

  task automatic test_clamp_and_busy_listen();
    int done_early;
    done_early = 0;
    arm(4'd0);
    for (int i = 0; i < 7; i++) begin
      // A listen with a tiny burst mid-capture must not reload the count.
      listen      = (i == 2);
      burst_words = 4'd1;
      toggle(16'(16'h0F00 + i));
      if (done || !busy) done_early++;
    end
    listen = 1'b0;
    total++;
    if (done_early != 0) begin
      bad++;
      $display("FAIL clamp_early: %0d early completions, want 0", done_early);
    end
    toggle(16'h0F07);
    total++;
    if (done !== 1'b1 || wr_ptr !== 3'd1) begin
      bad++;
      $display("FAIL clamp_end: done=%b wr_ptr=%0d, want 1/1", done, wr_ptr);
    end
    step();
    rd(0);
    total++;
    if (dout !== 16'h0F07) begin
      bad++;
      $display("FAIL clamp_wrap: dout=%h, want 0f07", dout);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset_n     = 1'b0;
    listen      = 1'b0;
    burst_words = 4'd0;
    strobe      = 1'b0;
    din         = 16'h0;
    rd_ptr      = 3'd0;
    test_reset();
    test_full_burst();
    test_half_bursts();
    test_stray();
    test_timeout();
    test_reset_mid_burst();
    test_read_latency();
    test_clamp_and_busy_listen();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
